// File: rtl/data_mem_unit.sv
// Data memory for the core: byte-addressed RAM plus a small MMIO block
// (cycle counter, sticky misalign status and last faulting address).
module data_mem_unit #(
  parameter int unsigned DEPTH_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        mem_write,
  input  logic        mem_read,
  input  logic [2:0]  funct3,
  output logic [31:0] rdata,
  output logic        misaligned
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam logic [31:0] RAM_BYTES  = 32'(4 * DEPTH_WORDS);
  localparam logic [31:0] A_CYCLES   = 32'hFFFF_FFF0;
  localparam logic [31:0] A_ERR_STAT = 32'hFFFF_FFF4;
  localparam logic [31:0] A_ERR_ADDR = 32'hFFFF_FFF8;

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] cycles_q, cycles_d;
  logic        err_q, err_d;
  logic [31:0] err_addr_q, err_addr_d;

  logic          is_b, is_h, is_w, is_bu, is_hu, valid;
  logic          ram_hit, mmio_hit, acc;
  logic [AW-1:0] widx;
  logic [31:0]   word, wd;
  logic [3:0]    be;
  logic [7:0]    rbyte;
  logic [15:0]   rhalf;
  logic          st_ok, ld_ok, ram_we, w1c;

  assign is_b  = (funct3 == 3'b000);
  assign is_h  = (funct3 == 3'b001);
  assign is_w  = (funct3 == 3'b010);
  assign is_bu = (funct3 == 3'b100);
  assign is_hu = (funct3 == 3'b101);
  assign valid = is_b | is_h | is_w | is_bu | is_hu;

  assign ram_hit  = (addr < RAM_BYTES);
  assign mmio_hit = (addr >= A_CYCLES) && (addr <= 32'hFFFF_FFFB);
  assign widx     = addr[AW+1:2];
  assign acc      = mem_read | mem_write;

  assign misaligned = acc &
    (((is_h | is_hu) & addr[0]) | (is_w & (addr[1:0] != 2'b00)));

  assign st_ok  = mem_write & valid & ~misaligned & ~rst;
  assign ld_ok  = mem_read & valid & ~misaligned;
  assign ram_we = st_ok & ram_hit;
  assign w1c    = st_ok & is_w & (addr == A_ERR_STAT) & wdata[0];

  always_comb begin
    be = 4'b0000;
    wd = wdata;
    unique case (1'b1)
      is_b:    begin be = 4'b0001 << addr[1:0]; wd = {4{wdata[7:0]}}; end
      is_h:    begin be = addr[1] ? 4'b1100 : 4'b0011; wd = {2{wdata[15:0]}}; end
      is_w:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  // RAM has no reset; contents survive rst
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem_q[widx][8*i +: 8] <= wd[8*i +: 8];
      end
    end
  end

  assign word  = mem_q[widx];
  assign rbyte = word[8*addr[1:0] +: 8];
  assign rhalf = addr[1] ? word[31:16] : word[15:0];

  always_comb begin
    rdata = 32'h0;
    if (ld_ok && ram_hit) begin
      unique case (1'b1)
        is_b:    rdata = {{24{rbyte[7]}}, rbyte};
        is_bu:   rdata = {24'h0, rbyte};
        is_h:    rdata = {{16{rhalf[15]}}, rhalf};
        is_hu:   rdata = {16'h0, rhalf};
        is_w:    rdata = word;
        default: rdata = 32'h0;
      endcase
    end else if (ld_ok && mmio_hit && is_w) begin
      unique case (1'b1)
        addr == A_CYCLES:   rdata = cycles_q;
        addr == A_ERR_STAT: rdata = {31'h0, err_q};
        addr == A_ERR_ADDR: rdata = err_addr_q;
        default:            rdata = 32'h0;
      endcase
    end
  end

  // A new fault wins over a simultaneous write-1-to-clear
  always_comb begin
    cycles_d   = cycles_q + 32'd1;
    err_d      = err_q;
    err_addr_d = err_addr_q;
    if (misaligned) begin
      err_d      = 1'b1;
      err_addr_d = addr;
    end else if (w1c) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cycles_q   <= 32'h0;
      err_q      <= 1'b0;
      err_addr_q <= 32'h0;
    end else begin
      cycles_q   <= cycles_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
    end
  end

endmodule

// File: tb/tb_data_mem_unit.sv
// Directed bench for data_mem_unit: loads/stores, extension,
// misalign handling, MMIO registers, reset abort.
module tb_data_mem_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        mem_write = 1'b0;
  logic        mem_read = 1'b0;
  logic [2:0]  funct3 = 3'b010;
  logic [31:0] rdata;
  logic        misaligned;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [2:0] FB = 3'b000, FH = 3'b001, FW = 3'b010;
  localparam logic [2:0] FBU = 3'b100, FHU = 3'b101;

  data_mem_unit #(.DEPTH_WORDS(256)) dut (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata),
    .mem_write(mem_write), .mem_read(mem_read), .funct3(funct3),
    .rdata(rdata), .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  task automatic st(input logic [31:0] a, input logic [31:0] d,
                    input logic [2:0] f, output logic m);
    @(negedge clk);
    addr = a; wdata = d; funct3 = f; mem_write = 1'b1;
    #1 m = misaligned;
    @(posedge clk);
    #1 mem_write = 1'b0;
  endtask

  task automatic ld(input logic [31:0] a, input logic [2:0] f,
                    output logic [31:0] d, output logic m);
    @(negedge clk);
    addr = a; funct3 = f; mem_read = 1'b1;
    #1 d = rdata; m = misaligned;
    mem_read = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] d; logic m;
    @(negedge clk); rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    n_cmp++;
    if (rdata !== 32'h0 || misaligned !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_outs got rdata=%h mis=%b want 0/0", rdata, misaligned);
    end
    ld(32'hFFFF_FFF4, FW, d, m);
    n_cmp++;
    if (d !== 32'h0) begin n_bad++; $display("FAIL reset_err got %h want 0", d); end
    ld(32'hFFFF_FFF8, FW, d, m);
    n_cmp++;
    if (d !== 32'h0) begin n_bad++; $display("FAIL reset_erraddr got %h want 0", d); end
  endtask

  task automatic test_extend;
    logic [31:0] d; logic m;
    st(32'h10, 32'h8000_00FF, FW, m);
    ld(32'h10, FB, d, m);
    n_cmp++;
    if (d !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL lb got %h want ffffffff", d); end
    ld(32'h10, FBU, d, m);
    n_cmp++;
    if (d !== 32'h0000_00FF) begin n_bad++; $display("FAIL lbu got %h want 000000ff", d); end
    ld(32'h12, FH, d, m);
    n_cmp++;
    if (d !== 32'hFFFF_8000) begin n_bad++; $display("FAIL lh got %h want ffff8000", d); end
    ld(32'h12, FHU, d, m);
    n_cmp++;
    if (d !== 32'h0000_8000) begin n_bad++; $display("FAIL lhu got %h want 00008000", d); end
    ld(32'h13, FB, d, m);
    n_cmp++;
    if (d !== 32'hFFFF_FF80) begin n_bad++; $display("FAIL lb3 got %h want ffffff80", d); end
    ld(32'h10, FW, d, m);
    n_cmp++;
    if (d !== 32'h8000_00FF) begin n_bad++; $display("FAIL lw got %h want 800000ff", d); end
  endtask

  task automatic test_merge;
    logic [31:0] d; logic m;
    st(32'h20, 32'h1122_3344, FW, m);
    st(32'h21, 32'h0000_00AA, FB, m);
    st(32'h22, 32'h0000_BEEF, FH, m);
    ld(32'h20, FW, d, m);
    n_cmp++;
    if (d !== 32'hBEEF_AA44) begin n_bad++; $display("FAIL merge got %h want beefaa44", d); end
  endtask

  task automatic test_misalign;
    logic [31:0] d; logic m;
    st(32'h04, 32'h1111_1111, FW, m);
    st(32'h06, 32'hDEAD_BEEF, FW, m);
    n_cmp++;
    if (m !== 1'b1) begin n_bad++; $display("FAIL mis_sw got %b want 1", m); end
    ld(32'h04, FW, d, m);
    n_cmp++;
    if (d !== 32'h1111_1111) begin n_bad++; $display("FAIL mis_nowrite got %h want 11111111", d); end
    ld(32'hFFFF_FFF4, FW, d, m);
    n_cmp++;
    if (d !== 32'h1) begin n_bad++; $display("FAIL err_set got %h want 1", d); end
    ld(32'hFFFF_FFF8, FW, d, m);
    n_cmp++;
    if (d !== 32'h6) begin n_bad++; $display("FAIL err_addr got %h want 6", d); end
    // misaligned load held across an edge: rdata 0, address recaptured
    @(negedge clk);
    addr = 32'h11; funct3 = FHU; mem_read = 1'b1;
    #1 n_cmp++;
    if (rdata !== 32'h0 || misaligned !== 1'b1) begin
      n_bad++;
      $display("FAIL mis_lhu got rdata=%h mis=%b want 0/1", rdata, misaligned);
    end
    @(posedge clk);
    #1 mem_read = 1'b0;
    ld(32'hFFFF_FFF8, FW, d, m);
    n_cmp++;
    if (d !== 32'h11) begin n_bad++; $display("FAIL err_addr2 got %h want 11", d); end
    st(32'hFFFF_FFF4, 32'h1, FB, m);
    ld(32'hFFFF_FFF4, FW, d, m);
    n_cmp++;
    if (d !== 32'h1) begin n_bad++; $display("FAIL sb_mmio_ign got %h want 1", d); end
    st(32'hFFFF_FFF4, 32'h1, FW, m);
    ld(32'hFFFF_FFF4, FW, d, m);
    n_cmp++;
    if (d !== 32'h0) begin n_bad++; $display("FAIL err_w1c got %h want 0", d); end
  endtask

  task automatic test_cycles;
    logic [31:0] d; logic m;
    @(negedge clk); rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    ld(32'hFFFF_FFF0, FW, d, m);
    n_cmp++;
    if (d !== 32'h0) begin n_bad++; $display("FAIL cyc_first got %h want 0", d); end
    repeat (5) @(posedge clk);
    ld(32'hFFFF_FFF0, FW, d, m);
    n_cmp++;
    if (d !== 32'd5) begin n_bad++; $display("FAIL cyc_n got %h want 5", d); end
    ld(32'hFFFF_FFF0, FB, d, m);
    n_cmp++;
    if (d !== 32'h0) begin n_bad++; $display("FAIL cyc_lb got %h want 0", d); end
    @(negedge clk);
    force dut.cycles_q = 32'hFFFF_FFFF;
    #1 release dut.cycles_q;
    addr = 32'hFFFF_FFF0; funct3 = FW; mem_read = 1'b1;
    #1 n_cmp++;
    if (rdata !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL cyc_max got %h want ffffffff", rdata); end
    @(posedge clk);
    #1 n_cmp++;
    if (rdata !== 32'h0) begin n_bad++; $display("FAIL cyc_wrap got %h want 0", rdata); end
    mem_read = 1'b0;
  endtask

  task automatic test_unmapped;
    logic [31:0] d; logic m;
    st(32'h0, 32'hCAFE_0000, FW, m);
    st(32'h2000, 32'h5, FW, m);
    ld(32'h0, FW, d, m);
    n_cmp++;
    if (d !== 32'hCAFE_0000) begin n_bad++; $display("FAIL unm_alias got %h want cafe0000", d); end
    ld(32'h2000, FW, d, m);
    n_cmp++;
    if (d !== 32'h0) begin n_bad++; $display("FAIL unm_ld got %h want 0", d); end
    ld(32'hFFFF_FFF4, FW, d, m);
    n_cmp++;
    if (d !== 32'h0) begin n_bad++; $display("FAIL unm_err got %h want 0", d); end
  endtask

  task automatic test_invalid;
    logic [31:0] d; logic m;
    st(32'h40, 32'h55, FW, m);
    st(32'h41, 32'hFFFF_FFFF, 3'b011, m);
    n_cmp++;
    if (m !== 1'b0) begin n_bad++; $display("FAIL inv_mis got %b want 0", m); end
    ld(32'h40, 3'b110, d, m);
    n_cmp++;
    if (d !== 32'h0) begin n_bad++; $display("FAIL inv_ld got %h want 0", d); end
    ld(32'h40, FW, d, m);
    n_cmp++;
    if (d !== 32'h55) begin n_bad++; $display("FAIL inv_st got %h want 55", d); end
    @(negedge clk);
    addr = 32'h40; funct3 = FW; mem_read = 1'b0;
    #1 n_cmp++;
    if (rdata !== 32'h0) begin n_bad++; $display("FAIL noread got %h want 0", rdata); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] d; logic m;
    st(32'h50, 32'hA, FW, m);
    @(negedge clk);
    addr = 32'h50; wdata = 32'hB; funct3 = FW;
    mem_write = 1'b1; mem_read = 1'b1;
    #1 n_cmp++;
    if (rdata !== 32'hA) begin n_bad++; $display("FAIL rw_pre got %h want a", rdata); end
    @(posedge clk);
    #1 mem_write = 1'b0; mem_read = 1'b0;
    ld(32'h50, FW, d, m);
    n_cmp++;
    if (d !== 32'hB) begin n_bad++; $display("FAIL rw_post got %h want b", d); end
  endtask

  task automatic test_reset_abort;
    logic [31:0] d; logic m;
    st(32'h30, 32'h0, FW, m);
    st(32'h33, 32'h0, FW, m);
    @(negedge clk);
    addr = 32'h30; wdata = 32'h1234; funct3 = FW;
    mem_write = 1'b1; rst = 1'b1;
    @(posedge clk);
    #1 mem_write = 1'b0; rst = 1'b0;
    ld(32'hFFFF_FFF0, FW, d, m);
    n_cmp++;
    if (d !== 32'h0) begin n_bad++; $display("FAIL abort_cyc got %h want 0", d); end
    ld(32'h30, FW, d, m);
    n_cmp++;
    if (d !== 32'h0) begin n_bad++; $display("FAIL abort_word got %h want 0", d); end
    ld(32'hFFFF_FFF4, FW, d, m);
    n_cmp++;
    if (d !== 32'h0) begin n_bad++; $display("FAIL abort_err got %h want 0", d); end
    ld(32'hFFFF_FFF8, FW, d, m);
    n_cmp++;
    if (d !== 32'h0) begin n_bad++; $display("FAIL abort_eaddr got %h want 0", d); end
  endtask

  initial begin
    test_reset;
    test_extend;
    test_merge;
    test_misalign;
    test_cycles;
    test_unmapped;
    test_invalid;
    test_back_to_back;
    test_reset_abort;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
